mult_8x8_seq_ctrl: RTL and testbench



---
 rtl/mult_pkg.sv | 23 ++
 rtl/R1_4x4_mul.sv | 23 ++
 rtl/mult_nibble_unit.sv | 25 ++
 rtl/mult_8x8_seq_ctrl.sv | 101 ++++++++++
 tb/tb_mult_8x8_seq_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
// Combine mode is selected by ORC_COMBINE_EN (see mult_8x8_seq_ctrl).
package mult_pkg;

  localparam int NIB_W = 4;
  localparam int OP_W  = 8;
  localparam int RES_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  function automatic logic [3:0] pp_shift(input logic [1:0] c);
    case (c)
      2'd0:    pp_shift = 4'd0;
      2'd3:    pp_shift = 4'd8;
      default: pp_shift = 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/R1_4x4_mul.sv
// Approximate 4x4 multiplier: the low 2x2 sub-product is
// formed with an OR in place of its middle-column carry.
module R1_4x4_mul (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [7:0] hh;
  logic [7:0] hl;
  logic [7:0] lh;
  logic [7:0] lo;

  assign hh = {6'b0, a[3:2]} * {6'b0, b[3:2]};
  assign hl = {6'b0, a[3:2]} * {6'b0, b[1:0]};
  assign lh = {6'b0, a[1:0]} * {6'b0, b[3:2]};
  assign lo = {5'b0, a[1] & b[1],
               (a[1] & b[0]) | (a[0] & b[1]),
               a[0] & b[0]};

  assign p = (hh << 4) + ((hl + lh) << 2) + lo;

endmodule

// File: rtl/mult_nibble_unit.sv
// Combinational 4x4 -> 8-bit nibble product.
// APPROX=0 is exact, APPROX=1 uses R1_4x4_mul.
import mult_pkg::*;

module mult_nibble_unit #(
  parameter int APPROX = 0
) (
  input  logic [NIB_W-1:0]   a,
  input  logic [NIB_W-1:0]   b,
  output logic [2*NIB_W-1:0] p
);

  generate
    if (APPROX == 0) begin : g_exact
      assign p = {{NIB_W{1'b0}}, a} * {{NIB_W{1'b0}}, b};
    end else begin : g_approx
      R1_4x4_mul u_r1 (
        .a (a),
        .b (b),
        .p (p)
      );
    end
  endgenerate

endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential 8x8 multiplier: one 4x4 partial product per cycle.
// ORC_COMBINE_EN selects OR-combine instead of exact add.
import mult_pkg::*;

module mult_8x8_seq_ctrl #(
  parameter int APPROX = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  A,
  input  logic [OP_W-1:0]  B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] R,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       cnt;
  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;
  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] acc_nxt;
  logic [RES_W-1:0] sh_pp;
  logic [NIB_W-1:0] na;
  logic [NIB_W-1:0] nb;
  logic [7:0]       pp;
  logic             accept;

  // cnt[1] picks the A nibble, cnt[0] the B nibble
  assign na = cnt[1] ? a_q[7:4] : a_q[3:0];
  assign nb = cnt[0] ? b_q[7:4] : b_q[3:0];

  mult_nibble_unit #(
    .APPROX (APPROX)
  ) u_nib (
    .a (na),
    .b (nb),
    .p (pp)
  );

  assign sh_pp = {8'b0, pp} << pp_shift(cnt);

`ifdef ORC_COMBINE_EN
  assign acc_nxt = acc | sh_pp;
`else
  assign acc_nxt = acc + sh_pp;
`endif

  assign accept = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (cnt == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? MUL : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q <= A;
        b_q <= B;
        acc <= '0;
        cnt <= 2'd0;
      end else if (state == MUL) begin
        acc <= acc_nxt;
        cnt <= cnt + 2'd1;
      end
    end
  end

  assign R = acc;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Directed self-checking bench for mult_8x8_seq_ctrl.
// Expectations follow ORC_COMBINE_EN when defined.
module tb_mult_8x8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] R;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef ORC_COMBINE_EN
  localparam logic [15:0] E_1234 = 16'h0368;
  localparam logic [15:0] E_FFFF = 16'hEFF1;
`else
  localparam logic [15:0] E_1234 = 16'h03A8;
  localparam logic [15:0] E_FFFF = 16'hFE01;
`endif

  mult_8x8_seq_ctrl #(.APPROX(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer a, b at a negedge, then wait for out_valid.
  // Leaves the bench at the negedge where out_valid is first seen.
  task automatic mul_op(input string tag,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [15:0] exp,
                        input logic hold_valid);
    int cyc;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    cyc = 0;
    while (!out_valid && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 4);
    chk({tag, "_R"}, R, exp);
  endtask

  initial begin
    int gap;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = 8'h00;
    B         = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_R", R, 0);

    // basic product, consumer ready
    out_ready = 1'b1;
    mul_op("p1234", 8'h12, 8'h34, E_1234, 1'b0);
    chk("p1234_done_in_ready", in_ready, 1);
    @(negedge clk);
    chk("p1234_ov_pulse", out_valid, 0);
    chk("p1234_idle", in_ready, 1);
    chk("p1234_R_hold", R, E_1234);

    mul_op("pffff", 8'hFF, 8'hFF, E_FFFF, 1'b0);
    @(negedge clk);
    mul_op("p005a", 8'h00, 8'h5A, 16'h0000, 1'b0);
    @(negedge clk);

    // backpressure
    out_ready = 1'b0;
    mul_op("bp", 8'h12, 8'h34, E_1234, 1'b0);
    A = 8'hAA;
    B = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_R", R, E_1234);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", out_valid, 0);
    chk("bp_idle", in_ready, 1);

    // back-to-back with in_valid held
    mul_op("b2b1", 8'h12, 8'h34, E_1234, 1'b1);
    A = 8'h0F;
    B = 8'h10;
    chk("b2b1_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_ov_drop", out_valid, 0);
    chk("b2b_busy", busy, 1);
    gap = 1;
    while (!out_valid && gap < 12) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b_spacing", gap, 5);
    chk("b2b2_R", R, 16'h00F0);
    @(negedge clk);

    // reset in the middle of a product
    A        = 8'h12;
    B        = 8'h34;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_R", R, 0);
    chk("mrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mrst_no_pulse", out_valid, 0);
    mul_op("p0305", 8'h03, 8'h05, 16'h000F, 1'b0);
    @(negedge clk);
    chk("p0305_idle", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
